main_memory_responder: RTL
==========================

# main_memory_responder

Backing-store responder on the memory side of `DirectCache32`. It accepts one word read or write per request from the cache's miss/write-through port (`mem_addr`, `mem_wr_data`, `mem_wr_en`, `mem_read`), models a fixed access latency with a countdown FSM, and signals completion with a one-cycle `mem_ready` pulse. It sits between the cache and the word-addressed main memory array.

## Interface
- `ADDR_BITS`, default 10: array depth is 2^ADDR_BITS words; legal range 1..20.
- `LATENCY`, default 4: cycles from request acceptance to `mem_ready`; legal range 1..255; 0 is illegal.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `mem_req` in 1: request strobe, sampled only in IDLE.
- `mem_addr` in 32: word address; bits [ADDR_BITS-1:0] index the array, upper bits ignored (aliasing).
- `mem_wr_en` in 1: 1 = write request, 0 = read request; sampled with `mem_req`.
- `mem_wr_data` in 32: write data; sampled with `mem_req`.
- `mem_read` out 32: read data; registered.
- `mem_ready` out 1: completion pulse, high for exactly one cycle per request.
- `busy` out 1: high in BUSY and DONE.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: on an edge with `mem_req`=1, latch addr index, `mem_wr_en`, and `mem_wr_data`; load counter with LATENCY-1; go to BUSY. With `mem_req`=0, stay in IDLE.
- BUSY: on each edge with counter≠0, decrement.
  - On the edge with counter=0, perform the access and go to DONE.
  - Write: commit the latched data to the array.
  - Read: load the array word into `mem_read`.
- DONE: `mem_ready`=1; next edge goes to IDLE.
- `mem_req`, `mem_addr`, `mem_wr_en`, and `mem_wr_data` are ignored outside IDLE. The requester may change them freely after acceptance.
- `mem_read` holds its value until the next read completes. Write completion leaves it unchanged.
- A read of an address written by an earlier completed request returns the new data. There is no read/write hazard because there is only one access at a time.
- Counter width is 8 bits; no wrap occurs because the load value is ≤ 254.

## Timing
- Request sampled at edge T0. BUSY spans LATENCY cycles. `mem_ready` is high from edge T0+LATENCY to edge T0+LATENCY+1.
- The earliest next acceptance is edge T0+LATENCY+2, so throughput is one request per LATENCY+2 cycles.
- LATENCY=1: BUSY lasts one cycle with counter=0 immediately.
- `mem_read` is valid in the same cycle that `mem_ready`=1.
- Reset (edge with `rst_n`=0) has priority over every other event:
  - State goes to IDLE; `mem_ready`=0, `busy`=0, `mem_read`=0; counter=0.
  - The array contents are not reset.
  - Reset during BUSY discards the pending access; a write not yet committed never reaches the array.
  - Reset during DONE drops the `mem_ready` pulse on the next cycle.
- `mem_req`=1 on the same edge reset is released (`rst_n` low) is ignored. The first acceptance is possible on the following edge.

## Structure
- Package `mem_resp_pkg`:
  - state enum (IDLE, BUSY, DONE);
  - `LAT_W`=8 counter width constant;
  - 32-bit word width constant.
- Sub-module `mem_array_sp`:
  - single-port synchronous RAM, parameterised by ADDR_BITS;
  - write enable, registered read data;
  - no reset on the storage.
- The top level holds the FSM, counter, and request latches only.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles -> `mem_ready`=0, `busy`=0, `mem_read`=0; no `mem_ready` while `mem_req`=0.
- Write then read, LATENCY=4:
  - write 0x00000003 to addr 0x12345679 -> `mem_ready` pulses exactly 4 cycles after acceptance, one cycle wide;
  - read of 0x12345679 -> `mem_read`=0x00000003 with `mem_ready`.
- Aliasing, ADDR_BITS=10: write 0x00000004 to 0x12345681, then read 0xAB345681 -> 0x00000004, because the low 10 bits match.
- Requests ignored while busy:
  - `mem_req` held high continuously with alternating addresses -> acceptances exactly every 6 cycles (LATENCY+2);
  - only addresses sampled in IDLE are serviced.
- Reset mid-write:
  - write 0xDEADBEEF to 0x10, assert `rst_n`=0 on the second BUSY cycle;
  - a later read of 0x10 -> the old value, and no `mem_ready` pulse appears for the aborted write.
- LATENCY=1 boundary: read -> `mem_ready` one cycle after acceptance; back-to-back reads accepted every 3 cycles.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the main-memory responder behind DirectCache32.
// Holds the FSM state encoding, the latency counter width and the data word width.
package mem_resp_pkg;

    localparam int LAT_W  = 8;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter load value: the last BUSY cycle is the one where the counter reads zero.
    function automatic logic [LAT_W-1:0] latency_load(input int latency);
        return LAT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port synchronous word RAM with registered read data, split into byte lanes.
// Storage is never reset; only the read-data register clears on rst_n.
module mem_array_sp
    import mem_resp_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wr_data,
    output logic [WORD_W-1:0]    rd_data
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int LANES = WORD_W / 8;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q_reg;

            always_ff @(posedge clk) begin
                if (en && we) begin
                    lane_mem[addr] <= wr_data[gi*8 +: 8];
                end
            end

            // Read register only moves on a read, so it holds across writes.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lane_q_reg <= 8'd0;
                end else if (en && !we) begin
                    lane_q_reg <= lane_mem[addr];
                end
            end

            assign rd_data[gi*8 +: 8] = lane_q_reg;
        end
    endgenerate

endmodule

// File: rtl/main_memory_responder.sv
// Backing-store responder: accepts one word read/write in IDLE, counts out a fixed
// latency in BUSY, performs the access, and pulses mem_ready for one cycle in DONE.
module main_memory_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic [31:0]       mem_addr,
    input  logic              mem_wr_en,
    input  logic [31:0]       mem_wr_data,
    output logic [31:0]       mem_read,
    output logic              mem_ready,
    output logic              busy
);

    generate
        if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
            $error("main_memory_responder: LATENCY must be in 1..255");
        end
        if (ADDR_BITS < 1 || ADDR_BITS > 20) begin : g_bad_addr_bits
            $error("main_memory_responder: ADDR_BITS must be in 1..20");
        end
    endgenerate

    localparam logic [LAT_W-1:0] CNT_LOAD = latency_load(LATENCY);

    state_t                 state_reg, state_next;
    logic [LAT_W-1:0]       cnt_reg, cnt_next;
    logic [ADDR_BITS-1:0]   addr_reg;
    logic                   wr_en_reg;
    logic [WORD_W-1:0]      wr_data_reg;
    logic                   access;
    logic                   ram_en;

    // Upper address bits alias onto the array and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[31:ADDR_BITS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg    <= '0;
            wr_en_reg   <= 1'b0;
            wr_data_reg <= '0;
        end else if (state_reg == IDLE && mem_req) begin
            addr_reg    <= mem_addr[ADDR_BITS-1:0];
            wr_en_reg   <= mem_wr_en;
            wr_data_reg <= mem_wr_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        access     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (mem_req) begin
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset wins over a completing access, so an uncommitted write never lands.
    assign ram_en = access && rst_n;

    mem_array_sp #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (ram_en),
        .we      (wr_en_reg),
        .addr    (addr_reg),
        .wr_data (wr_data_reg),
        .rd_data (mem_read)
    );

    assign mem_ready = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);

endmodule
